// File: rtl/fir_serial_mac_param.sv
// Serial FIR filter: one signed MAC unit steps through all taps for each accepted sample.
// The coefficient bank is runtime-loadable and the result is held under AXI-Stream backpressure.
module fir_serial_mac_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 19,
    parameter int ACC_W  = 34,
    parameter int AW     = 5
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_data_tvalid,
    output logic                     s_axis_data_tready,
    input  logic signed [DATA_W-1:0] s_axis_data_tdata,
    output logic                     m_axis_data_tvalid,
    input  logic                     m_axis_data_tready,
    output logic signed [ACC_W-1:0]  m_axis_data_tdata,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     busy
);

    localparam int              PROD_W   = DATA_W + COEF_W;
    localparam logic [AW-1:0]   LAST_IDX = AW'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                     r_state;
    logic [AW-1:0]              r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_m_tdata;
    logic                       r_m_tvalid;
    logic                       r_s_tready;
    logic signed [DATA_W-1:0]   r_delay [NTAPS];
    logic signed [COEF_W-1:0]   r_coef  [NTAPS];

    logic signed [DATA_W-1:0]   w_delay_next [NTAPS];
    logic signed [DATA_W-1:0]   w_tap_d;
    logic signed [COEF_W-1:0]   w_tap_c;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic                       w_in_hs;
    logic                       w_out_hs;
    logic                       w_coef_wr;

    // r_s_tready is only ever high in IDLE, so it alone qualifies the input handshake
    assign w_in_hs   = s_axis_data_tvalid & r_s_tready;
    assign w_out_hs  = r_m_tvalid & m_axis_data_tready;
    assign w_coef_wr = coef_we & (r_state == S_IDLE) & ~w_in_hs
                     & ({1'b0, coef_addr} < (AW + 1)'(NTAPS));

    assign w_tap_d    = r_delay[r_idx];
    assign w_tap_c    = r_coef[r_idx];
    assign w_prod     = w_tap_d * w_tap_c;
    assign w_prod_ext = ACC_W'(w_prod);

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap
            if (gi == 0) begin : g_head
                assign w_delay_next[gi] = s_axis_data_tdata;
            end else begin : g_shift
                assign w_delay_next[gi] = r_delay[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_delay[i] <= '0;
            end
        end else if (w_in_hs) begin
            r_delay <= w_delay_next;
        end
    end

    // Coefficient bank deliberately survives reset
    always_ff @(posedge aclk) begin
        if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_acc      <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_hs) begin
                        r_state    <= S_MAC;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_s_tready <= 1'b0;
                    end else begin
                        r_s_tready <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_OUT: begin
                    // First OUT cycle publishes the sum; afterwards wait for the consumer
                    if (!r_m_tvalid) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= r_acc;
                    end else if (w_out_hs) begin
                        r_m_tvalid <= 1'b0;
                        r_s_tready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_data_tready = r_s_tready;
    assign m_axis_data_tvalid = r_m_tvalid;
    assign m_axis_data_tdata  = r_m_tdata;
    assign busy               = (r_state != S_IDLE);

endmodule
